// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared types and constants for the NES gamepad reader.
// Contents: reader FSM state enum, protocol tick counts, button bit indices
// (bit order as presented on the buttons output / CPU GIO_pins).
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    READ0,
    CLK_HI,
    CLK_LO,
    DONE
  } state_e;

  localparam int LATCH_TICKS = 2;
  localparam int NUM_BITS    = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_tick_gen.sv
// nes_tick_gen: free-running prescaler producing the protocol tick.
// Ports: clk, reset (sync, active-low), tick (high for one clk every TICK_DIV clks,
// on the cycle the count equals TICK_DIV-1). Not gated by anything; runs from reset.
module nes_tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls one NES pad (latch + 8 clocked bits) and presents an
// active-high button vector with a one-cycle buttons_valid pulse per frame.
// Ports: clk, reset (sync, active-low), nes_data (async, active-low pad data),
// nes_latch / nes_clk (pad strobes), buttons[7:0] (bit0 A .. bit7 Right), buttons_valid.
// Option: define NES_PAD_DEBOUNCE_EN to update buttons only when two consecutive
// frames read the same raw vector.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int TICK_DIV   = 300,
  parameter int IDLE_TICKS = 2759
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int CNT_MAX = (IDLE_TICKS > LATCH_TICKS) ? IDLE_TICKS : LATCH_TICKS;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NUM_BITS + 1);

  logic          tick;
  logic [1:0]    sync_q;
  logic          data_s;
  state_e        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          latch_q, latch_d;
  logic          nclk_q, nclk_d;
  logic [7:0]    btn_q, btn_d;
  logic          vld_q, vld_d;
`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0]    prev_q, prev_d;
`endif

  nes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Pad data is asynchronous to clk; only the second stage is ever sampled.
  assign data_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    vld_d   = 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
    prev_d  = prev_q;
`endif

    case (state_q)
      IDLE: if (tick) begin
        if (tcnt_q == CW'(IDLE_TICKS - 1)) begin
          state_d = LATCH;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      LATCH: if (tick) begin
        if (tcnt_q == CW'(LATCH_TICKS - 1)) begin
          state_d = READ0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      READ0: if (tick) begin
        shift_d[BTN_A] = ~data_s;
        idx_d          = IW'(1);
        state_d        = CLK_HI;
      end
      CLK_HI: if (tick) state_d = CLK_LO;
      CLK_LO: if (tick) begin
        // The 8th pulse (index 8) shifts the pad past its last bit; its sample is dropped.
        if (idx_q <= IW'(NUM_BITS - 1)) shift_d[idx_q[2:0]] = ~data_s;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_BITS)) state_d = DONE;
        else                        state_d = CLK_HI;
      end
      DONE: begin
        // Single clk cycle; idle count restarts so the frame stays IDLE_TICKS+19 ticks.
        state_d = IDLE;
        tcnt_d  = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
        idx_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with the state itself.
    latch_d = (state_d == LATCH);
    nclk_d  = (state_d == CLK_HI);
    if (state_d == DONE) begin
      vld_d = 1'b1;
`ifdef NES_PAD_DEBOUNCE_EN
      if (shift_q == prev_q) btn_d = shift_q;
      prev_d = shift_q;
`else
      btn_d = shift_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      tcnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= 8'h00;
      latch_q <= 1'b0;
      nclk_q  <= 1'b0;
      btn_q   <= 8'h00;
      vld_q   <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q  <= 8'h00;
`endif
    end else begin
      sync_q  <= {sync_q[0], nes_data};
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      latch_q <= latch_d;
      nclk_q  <= nclk_d;
      btn_q   <= btn_d;
      vld_q   <= vld_d;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign nes_latch     = latch_q;
  assign nes_clk       = nclk_q;
  assign buttons       = btn_q;
  assign buttons_valid = vld_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed + random frames against a 4021-style pad model and
// a frame-level expected-value model (protocol timing from tick arithmetic).
// Ports: none (top-level bench). Honours NES_PAD_DEBOUNCE_EN in its expectations.
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int TD    = 4;
  localparam int IT    = 3;
  localparam int FRAME = (IT + 19) * TD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_data = 1'b1;
  logic       nes_latch, nes_clk, buttons_valid;
  logic [7:0] buttons;

  int checks = 0;
  int failures = 0;

  // Pad model state: buttons held on the pad and the current shift position.
  logic [7:0] pressed = 8'h00;
  int         pos = 8;
  logic       pad_pclk = 1'b0;

  // Frame-level expectation model.
  logic [7:0] exp_btn = 8'h00;
  logic [7:0] prev_raw = 8'h00;

  nes_pad_reader #(.TICK_DIV(TD), .IDLE_TICKS(IT)) dut (
    .clk           (clk),
    .reset         (reset),
    .nes_data      (nes_data),
    .nes_latch     (nes_latch),
    .nes_clk       (nes_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid)
  );

  always #5 clk = ~clk;

  // 4021-like pad: latch loads (output = A), each rising nes_clk advances one bit;
  // past the last bit the line reads released (1).
  always @(negedge clk) begin
    if (nes_latch) pos = 0;
    else if (nes_clk && !pad_pclk) pos = pos + 1;
    pad_pclk = nes_clk;
    nes_data = (pos < 8) ? ~pressed[pos[2:0]] : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_btn  = 8'h00;
    prev_raw = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] raw);
`ifdef NES_PAD_DEBOUNCE_EN
    if (raw == prev_raw) exp_btn = raw;
    prev_raw = raw;
`else
    exp_btn = raw;
`endif
  endtask

  // Steps one negedge at a time from now until the next buttons_valid (bounded),
  // recording strobe timing measured in clk cycles.
  task automatic measure_frame(output int lat_rise, output int lat_hi, output int pulses,
                               output int hi_min, output int hi_max, output int lo_min,
                               output int lo_max, output int vld_at,
                               output logic [7:0] btn_at, output bit held);
    logic       pl, pc;
    int         rise_c, fall_c, len;
    logic [7:0] b0;
    lat_rise = -1; lat_hi = 0; pulses = 0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    vld_at = -1; btn_at = 8'hxx; held = 1'b1;
    rise_c = 0; fall_c = -1;
    b0 = buttons; pl = nes_latch; pc = nes_clk;
    for (int n = 1; n <= FRAME + 40 && vld_at < 0; n++) begin
      @(negedge clk);
      if (nes_latch && !pl && lat_rise < 0) lat_rise = n;
      if (nes_latch) lat_hi++;
      if (nes_clk && !pc) begin
        pulses++;
        rise_c = n;
        if (fall_c >= 0) begin
          len = n - fall_c;
          if (len < lo_min) lo_min = len;
          if (len > lo_max) lo_max = len;
        end
      end
      if (!nes_clk && pc) begin
        len = n - rise_c;
        if (len < hi_min) hi_min = len;
        if (len > hi_max) hi_max = len;
        fall_c = n;
      end
      if (buttons_valid) begin
        vld_at = n;
        btn_at = buttons;
      end else if (buttons !== b0) begin
        held = 1'b0;
      end
      pl = nes_latch;
      pc = nes_clk;
    end
  endtask

  initial begin
    int         lr, lh, np, hmin, hmax, lmin, lmax, va, rises;
    logic [7:0] ba, raw;
    bit         hd, found;
    logic       pc;
    logic [7:0] dirs [3];

    // Reset held low for 3 cycles: every output at its reset value.
    reset = 1'b0;
    pressed = 8'h00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {21'd0, nes_latch, nes_clk, buttons_valid, buttons}, 32'd0);
    end

    // First frame, pad released (data line stays 1): full timing check.
    reset = 1'b1;
    measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
    model_frame(8'h00);
    check("first_latch_rise", lr, IT * TD);
    check("latch_high_cycles", lh, 2 * TD);
    check("nes_clk_pulses", np, 8);
    check("nes_clk_hi_min", hmin, TD);
    check("nes_clk_hi_max", hmax, TD);
    check("nes_clk_lo_min", lmin, TD);
    check("nes_clk_lo_max", lmax, TD);
    check("first_valid_cycle", va, FRAME);
    check("released_buttons", ba, exp_btn);
    check("buttons_held_f0", hd, 1);
    @(negedge clk);
    check("valid_one_cycle", buttons_valid, 0);
    check("buttons_after_valid", buttons, exp_btn);

    // Directed patterns: A+Right, Start only, all released.
    dirs[0] = 8'h00; dirs[0][BTN_A] = 1'b1; dirs[0][BTN_RIGHT] = 1'b1;
    dirs[1] = 8'h00; dirs[1][BTN_START] = 1'b1;
    dirs[2] = 8'h00;
    // Resync to a frame boundary before the directed frames.
    measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
    model_frame(8'h00);
    for (int k = 0; k < 3; k++) begin
      pressed = dirs[k];
      measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
      model_frame(dirs[k]);
      check("dir_period", va, FRAME);
      check("dir_buttons", ba, exp_btn);
      check("dir_held", hd, 1);
      check("dir_pulses", np, 8);
    end

    // Random patterns.
    for (int k = 0; k < 6; k++) begin
      raw = 8'($urandom);
      pressed = raw;
      measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
      model_frame(raw);
      check("rnd_period", va, FRAME);
      check("rnd_buttons", ba, exp_btn);
      check("rnd_held", hd, 1);
    end

    // Reset during CLK_HI of bit 4 with Up pressed.
    pressed = 8'h00;
    pressed[BTN_UP] = 1'b1;
    rises = 0; found = 1'b0; pc = nes_clk;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      @(negedge clk);
      if (nes_clk && !pc) begin
        rises++;
        if (rises == 4) found = 1'b1;
      end
      pc = nes_clk;
    end
    check("rst_mid_found", found, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {21'd0, nes_latch, nes_clk, buttons_valid, buttons}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_hold", {21'd0, nes_latch, nes_clk, buttons_valid, buttons}, 32'd0);
    model_reset();
    reset = 1'b1;
    measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
    model_frame(pressed);
    check("post_rst_latch_rise", lr, IT * TD);
    check("post_rst_valid_cycle", va, FRAME);
    check("post_rst_zero_until_done", hd, 1);
    check("post_rst_buttons", ba, exp_btn);

    // Raw sequence 0x01, 0x02, 0x02 (exercises the debounce option when built in).
    dirs[0] = 8'h01; dirs[1] = 8'h02; dirs[2] = 8'h02;
    for (int k = 0; k < 3; k++) begin
      pressed = dirs[k];
      measure_frame(lr, lh, np, hmin, hmax, lmin, lmax, va, ba, hd);
      model_frame(dirs[k]);
      check("seq_buttons", ba, exp_btn);
      check("seq_period", va, FRAME);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
